// File: rtl/cover_stim_pkg.sv
// Shared types and width helpers for the cover/assertion stimulus generator.
package cover_stim_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DLY_W_DEF = 4;
    localparam int ST_W      = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE,
        FIRE_A,
        WAIT_DLY,
        FIRE_B,
        WAIT_RESP,
        GAP,
        DONE
    } state_e;

    typedef enum logic {
        EXP_PASS,
        EXP_FAIL
    } exp_e;

    // One timer covers both the response timeout and the extended gap.
    function automatic int tmr_w(input int timeout, input int gap);
        return $clog2(timeout + gap + 1);
    endfunction

endpackage

// File: rtl/cover_stim_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
module cover_stim_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cover_stim_gen.sv
// Drives a/b trials into an assertion checker and scores its pass/fail
// responses against the expected outcome of each trial.
module cover_stim_gen
    import cover_stim_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DLY_W   = DLY_W_DEF,
    parameter int TIMEOUT = 16,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_trials,
    input  logic [DLY_W-1:0] delay,
    input  logic [DLY_W-1:0] inject_period,
    input  logic             assertion_pass,
    input  logic             assertion_fail,
    input  logic             assertion_active,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int TW = tmr_w(TIMEOUT, GAP_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ntr_q, ntr_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DLY_W-1:0] per_q, per_d;
    logic [DLY_W-1:0] dcnt_q, dcnt_d;
    logic [DLY_W-1:0] inj_cnt_q, inj_cnt_d;
    exp_e             exp_q, exp_d;
    logic             resp_q, resp_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic clr;
    logic capture;
    logic go_a;
    logic pass_inc;
    logic fail_inc;
    logic tmo_inc;
    logic mis_inc;

    always_comb begin
        state_d   = state_q;
        ntr_d     = ntr_q;
        idx_d     = idx_q;
        dly_d     = dly_q;
        per_d     = per_q;
        dcnt_d    = dcnt_q;
        inj_cnt_d = inj_cnt_q;
        exp_d     = exp_q;
        resp_d    = resp_q;
        tmr_d     = tmr_q;
        clr       = 1'b0;
        go_a      = 1'b0;
        pass_inc  = 1'b0;
        fail_inc  = 1'b0;
        tmo_inc   = 1'b0;
        mis_inc   = 1'b0;

        // First response of a trial closes it; later ones are ignored.
        capture = (state_q inside {FIRE_A, WAIT_DLY, FIRE_B, WAIT_RESP})
                  && !resp_q && (assertion_pass || assertion_fail);
        if (capture) begin
            resp_d   = 1'b1;
            pass_inc = assertion_pass && !assertion_fail;
            fail_inc = assertion_fail;
            mis_inc  = (assertion_pass && assertion_fail)
                       || (assertion_fail != (exp_q == EXP_FAIL));
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    ntr_d     = num_trials;
                    dly_d     = delay;
                    per_d     = inject_period;
                    inj_cnt_d = inject_period;
                    idx_d     = '0;
                    if (num_trials == '0) begin
                        state_d = DONE;
                    end else begin
                        go_a = 1'b1;
                    end
                end
            end
            FIRE_A: begin
                if (dly_q == '0) begin
                    state_d = WAIT_RESP;
                    tmr_d   = '0;
                end else if (dly_q == DLY_W'(1)) begin
                    state_d = FIRE_B;
                end else begin
                    dcnt_d  = dly_q - DLY_W'(2);
                    state_d = WAIT_DLY;
                end
            end
            WAIT_DLY: begin
                if (dcnt_q == '0) begin
                    state_d = FIRE_B;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            FIRE_B: begin
                tmr_d   = '0;
                state_d = (resp_q || capture) ? GAP : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (resp_q || capture) begin
                    state_d = GAP;
                    tmr_d   = '0;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    tmo_inc = 1'b1;
                    mis_inc = 1'b1;
                    state_d = GAP;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GAP: begin
                if ((tmr_q >= TW'(GAP_CYC - 1)) &&
                    (!assertion_active ||
                     (tmr_q >= TW'(GAP_CYC - 1 + TIMEOUT)))) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_d == ntr_q) begin
                        state_d = DONE;
                    end else begin
                        go_a = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Trial entry: decide injection from the down-counter, then advance it.
        if (go_a) begin
            state_d = FIRE_A;
            resp_d  = 1'b0;
            if ((per_d != '0) && (inj_cnt_d == DLY_W'(1))) begin
                exp_d = EXP_FAIL;
            end else begin
                exp_d = EXP_PASS;
            end
            if (per_d != '0) begin
                if (inj_cnt_d == DLY_W'(1)) begin
                    inj_cnt_d = per_d;
                end else begin
                    inj_cnt_d = inj_cnt_d - 1'b1;
                end
            end
        end

        a_d    = (state_d == FIRE_A);
        b_d    = ((state_d == FIRE_B) || ((state_d == FIRE_A) && (dly_d == '0)))
                 && (exp_d == EXP_PASS);
        busy_d = !(state_d inside {IDLE, DONE});
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ntr_q     <= '0;
            idx_q     <= '0;
            dly_q     <= '0;
            per_q     <= '0;
            dcnt_q    <= '0;
            inj_cnt_q <= '0;
            exp_q     <= EXP_PASS;
            resp_q    <= 1'b0;
            tmr_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ntr_q     <= ntr_d;
            idx_q     <= idx_d;
            dly_q     <= dly_d;
            per_q     <= per_d;
            dcnt_q    <= dcnt_d;
            inj_cnt_q <= inj_cnt_d;
            exp_q     <= exp_d;
            resp_q    <= resp_d;
            tmr_q     <= tmr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign busy = busy_q;
    assign done = done_q;

    cover_stim_sat_cnt #(.W(CNT_W)) u_pass_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(pass_inc), .cnt(pass_cnt)
    );
    cover_stim_sat_cnt #(.W(CNT_W)) u_fail_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(fail_inc), .cnt(fail_cnt)
    );
    cover_stim_sat_cnt #(.W(CNT_W)) u_tmo_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(tmo_inc), .cnt(timeout_cnt)
    );
    cover_stim_sat_cnt #(.W(CNT_W)) u_mis_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(mis_inc), .cnt(mismatch_cnt)
    );

endmodule

// File: doc/cover_stim_gen.md
Name: cover_stim_gen

Overview:
- Stimulus transmitter for the generated cover/assertion checker RTL.
- Drives the checker's `a`/`b` inputs as a programmable series of trials: pulse `a`, then pulse `b` a fixed number of cycles later.
- Selected trials deliberately omit `b` (fault injection).
- Consumes the checker's pass/fail outputs, scores them against expectation and exposes counters, so checker RTL can be self-checked in silicon/emulation without a testbench.

Parameters:
- CNT_W, 16, width of trial count and result counters.
- DLY_W, 4, width of `delay` and `inject_period`.
- TIMEOUT, 16, max WAIT_RESP cycles before a trial is declared timed out.
- GAP_CYC, 2, idle cycles between trials (a=b=0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle start request; honoured only in IDLE.
- num_trials  in  CNT_W  trials to run; latched at start.
- delay  in  DLY_W  cycles from `a` pulse to `b` pulse (0 = same cycle); latched at start.
- inject_period  in  DLY_W  every Nth trial omits `b`; 0 = never; latched at start.
- assertion_pass  in  1  checker pass pulse.
- assertion_fail  in  1  checker fail pulse.
- assertion_active  in  1  checker in-flight flag; observed only for GAP extension.
- a  out  1  stimulus to checker.
- b  out  1  stimulus to checker.
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt  out  CNT_W  observed passes.
- fail_cnt  out  CNT_W  observed fails.
- timeout_cnt  out  CNT_W  trials with no response.
- mismatch_cnt  out  CNT_W  trials where observed result differs from expected.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - a, b, busy, done = 0.
  - All counters = 0.
  - Internal trial index, delay counter and inject counter = 0.
- FSM states: IDLE, FIRE_A, WAIT_DLY, FIRE_B, WAIT_RESP, GAP, DONE.
- IDLE:
  - On start, latch config and clear all four counters.
  - num_trials==0 -> DONE; otherwise -> FIRE_A.
  - start outside IDLE is ignored.
- FIRE_A (1 cycle):
  - a=1.
  - Injected = (inject_period!=0) and (1-based trial index mod inject_period == 0), tracked by a down-counter reloaded to inject_period.
  - If delay==0: b = !injected in this same cycle, then -> WAIT_RESP.
  - If delay==1: -> FIRE_B.
  - Otherwise: load delay-2 and -> WAIT_DLY.
- WAIT_DLY: a=b=0; count down; at 0 -> FIRE_B. Net effect: b is asserted exactly `delay` cycles after a.
- FIRE_B (1 cycle): b = !injected. If a response is already latched -> GAP, else -> WAIT_RESP.
- Response capture:
  - Sampled every cycle from FIRE_A through WAIT_RESP; the first response closes the trial and later ones are ignored until the next FIRE_A.
  - pass only: pass_cnt++.
  - fail only, or pass and fail in the same cycle: fail_cnt++. The simultaneous case also forces mismatch_cnt++.
  - Expected result is fail if injected, else pass; mismatch_cnt++ on disagreement.
- WAIT_RESP:
  - Response -> GAP.
  - No response after TIMEOUT cycles -> timeout_cnt++, mismatch_cnt++, -> GAP.
- GAP:
  - a=b=0 for GAP_CYC cycles.
  - The gap extends while assertion_active=1, capped at TIMEOUT extra cycles.
  - Then trial index++. Index==num_trials -> DONE, else -> FIRE_A.
- DONE: done=1 for one cycle, busy=0, -> IDLE.
- Counters saturate at 2^CNT_W-1 and hold their values until the next accepted start.
- a and b are registered outputs. Any reset mid-run aborts immediately, with no done pulse.

Decomposition:
- Package cover_stim_pkg holds:
  - FSM state enum type;
  - localparam widths derived from CNT_W and DLY_W;
  - expected-result enum (EXP_PASS, EXP_FAIL).
- One sub-module, cover_stim_sat_cnt: saturating counter with clear and increment enable, width parameter, async active-low reset. It is instantiated four times.

Test Plan:
- Bench responder pulses assertion_pass 1 cycle after a `b` seen 3 cycles after `a`, else pulses fail.
- Test 1: num_trials=5, delay=3, inject_period=0 -> b exactly 3 cycles after each a; pass_cnt=5, fail_cnt=0, mismatch_cnt=0; done pulses once.
- Test 2: num_trials=6, delay=3, inject_period=3 -> b absent on trials 3 and 6; pass_cnt=4, fail_cnt=2, mismatch_cnt=0.
- Test 3: responder silent, num_trials=2, TIMEOUT=16 -> timeout_cnt=2, mismatch_cnt=2, pass_cnt=fail_cnt=0; each WAIT_RESP lasts 16 cycles.
- Test 4: delay=0 and num_trials=0 -> a and b high in the same cycle for delay=0; num_trials=0 gives done one cycle after start with busy never asserted.
- Test 5: rst_n low during WAIT_DLY of trial 2 -> a=b=busy=0 and counters=0 immediately; no done; a subsequent start runs cleanly.
- Test 6: responder pulses pass and fail together -> fail_cnt=1, mismatch_cnt=1; a start pulse while busy is ignored.
